// File: rtl/piece_dispenser.sv
// Piece dispenser: pulls the next piece from the preview queue after a lock delay and offers it.
// Optional hold slot is built only when PIECE_HOLD_EN is defined.
module piece_dispenser #(
    parameter int unsigned SPAWN_DELAY = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_game_active,
    input  logic [2:0] i_queue_head,
    output logic       o_pieces_remove,
    input  logic       i_spawn_req,
    input  logic       i_hold_req,
    output logic       o_spawn_valid,
    input  logic       i_spawn_ready,
    output logic [2:0] o_spawn_piece,
    output logic [2:0] o_hold_piece,
    output logic       o_hold_used
);

    localparam logic [2:0] BLANK = 3'd0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DELAY  = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_OFFER  = 3'd3;
    localparam logic [2:0] S_ACTIVE = 3'd4;

    localparam logic [7:0] DELAY_LOAD = 8'(SPAWN_DELAY - 1);

    logic [2:0] r_state;
    logic [7:0] r_count;
    logic [2:0] r_spawn_piece;

    logic [2:0] w_state_next;
    logic [7:0] w_count_next;
    logic [2:0] w_spawn_next;
    logic       w_hold_take;
    logic [2:0] w_hold_stored;

`ifdef PIECE_HOLD_EN
    logic [2:0] r_hold_piece;
    logic       r_hold_used;

    // A lock in the same cycle wins over a hold request.
    assign w_hold_take   = (r_state == S_ACTIVE) && i_hold_req && !i_spawn_req && !r_hold_used;
    assign w_hold_stored = r_hold_piece;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_game_active) begin
            r_hold_piece <= BLANK;
            r_hold_used  <= 1'b0;
        end else if ((r_state == S_ACTIVE) && i_spawn_req) begin
            r_hold_used  <= 1'b0;
        end else if (w_hold_take) begin
            r_hold_piece <= r_spawn_piece;
            r_hold_used  <= 1'b1;
        end
    end

    assign o_hold_piece = r_hold_piece;
    assign o_hold_used  = r_hold_used;
`else
    logic w_unused_hold_req;

    assign w_unused_hold_req = i_hold_req;
    assign w_hold_take       = 1'b0;
    assign w_hold_stored     = BLANK;
    assign o_hold_piece      = BLANK;
    assign o_hold_used       = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_spawn_next = r_spawn_piece;
        case (r_state)
            S_IDLE: begin
                if (i_game_active) begin
                    w_state_next = S_DELAY;
                    w_count_next = DELAY_LOAD;
                end
            end
            S_DELAY: begin
                if (r_count == 8'd0) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_count_next = r_count - 8'd1;
                end
            end
            S_FETCH: begin
                if (i_queue_head != BLANK) begin
                    w_spawn_next = i_queue_head;
                    w_state_next = S_OFFER;
                end
            end
            S_OFFER: begin
                if (i_spawn_ready) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (i_spawn_req) begin
                    w_state_next = S_DELAY;
                    w_count_next = DELAY_LOAD;
                    w_spawn_next = BLANK;
                end else if (w_hold_take) begin
                    // Empty slot: refill from the queue at once; otherwise swap with the slot.
                    if (w_hold_stored == BLANK) begin
                        w_state_next = S_FETCH;
                        w_spawn_next = BLANK;
                    end else begin
                        w_state_next = S_OFFER;
                        w_spawn_next = w_hold_stored;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = 8'd0;
                w_spawn_next = BLANK;
            end
        endcase
        if (!i_game_active) begin
            w_state_next = S_IDLE;
            w_count_next = 8'd0;
            w_spawn_next = BLANK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_count       <= 8'd0;
            r_spawn_piece <= BLANK;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_spawn_piece <= w_spawn_next;
        end
    end

    assign o_pieces_remove = !i_rst && i_game_active && (r_state == S_FETCH)
                             && (i_queue_head != BLANK);
    assign o_spawn_valid   = (r_state == S_OFFER);
    assign o_spawn_piece   = r_spawn_piece;

endmodule

// File: tb/tb_piece_dispenser.sv
// Randomised bench for piece_dispenser: a game-level model predicts fetch/offer timing and hold
// state, and a monitor compares the DUT against those predictions.
module tb_piece_dispenser;

    localparam int unsigned SD = 4;
`ifdef PIECE_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam logic [2:0] BLANK = 3'd0;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_active;
    logic [2:0] queue_head;
    logic       pieces_remove;
    logic       spawn_req;
    logic       hold_req;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [2:0] spawn_piece;
    logic [2:0] hold_piece;
    logic       hold_used;

    always #5 clk = ~clk;

    piece_dispenser #(.SPAWN_DELAY(SD)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_game_active  (game_active),
        .i_queue_head   (queue_head),
        .o_pieces_remove(pieces_remove),
        .i_spawn_req    (spawn_req),
        .i_hold_req     (hold_req),
        .o_spawn_valid  (spawn_valid),
        .i_spawn_ready  (spawn_ready),
        .o_spawn_piece  (spawn_piece),
        .o_hold_piece   (hold_piece),
        .o_hold_used    (hold_used)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Next-pieces queue environment: consumed on each removal pulse, with random empty gaps.
    logic [2:0] bag [0:1023];
    int env_ptr    = 0;
    int blank_left = 0;

    assign queue_head = (blank_left > 0) ? BLANK : bag[env_ptr % 1024];

    always @(posedge clk) begin
        if (pieces_remove) begin
            env_ptr    <= env_ptr + 1;
            blank_left <= ($urandom_range(0, 6) == 0) ? 10 : int'($urandom_range(0, 2));
        end else if (blank_left > 0) begin
            blank_left <= blank_left - 1;
        end
    end

    typedef struct {
        logic [2:0] piece;
        int         due;
    } offer_t;

    typedef struct {
        int         at;
        logic [2:0] spawn;
        logic [2:0] hold;
        logic       used;
        logic       valid;
    } chk_t;

    offer_t exp_q[$];
    int     fetch_q[$];
    chk_t   chk_q[$];

    // Monitor
    logic prev_remove = 1'b0;
    logic prev_quiet  = 1'b0;
    logic in_offer    = 1'b0;
    int   last_fetch  = 0;

    always @(negedge clk) begin
        if (prev_quiet) begin
            check("quiet_valid", 32'(spawn_valid), 0);
            check("quiet_spawn_piece", 32'(spawn_piece), 0);
            check("quiet_hold_piece", 32'(hold_piece), 0);
            check("quiet_hold_used", 32'(hold_used), 0);
            in_offer = 1'b0;
        end
        if (rst || !game_active) begin
            check("remove_when_quiet", 32'(pieces_remove), 0);
        end else begin
            if (pieces_remove) begin
                check("remove_head_nonblank", 32'(queue_head != BLANK), 1);
                check("remove_not_back_to_back", 32'(prev_remove), 0);
                check("remove_expected", 32'(fetch_q.size() > 0), 1);
                if (fetch_q.size() > 0) begin
                    check("remove_not_early", 32'(cyc >= fetch_q[0]), 1);
                    void'(fetch_q.pop_front());
                end
                last_fetch = cyc;
            end else if (fetch_q.size() > 0 && cyc >= fetch_q[0] && queue_head != BLANK) begin
                check("remove_missed", 32'(pieces_remove), 1);
                void'(fetch_q.pop_front());
            end
            if (spawn_valid) begin
                check("offer_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    if (!in_offer) begin
                        in_offer = 1'b1;
                        check("offer_timing", cyc,
                              (exp_q[0].due >= 0) ? exp_q[0].due : last_fetch + 1);
                    end
                    check("offer_piece", 32'(spawn_piece), 32'(exp_q[0].piece));
                    if (spawn_ready) begin
                        void'(exp_q.pop_front());
                        in_offer = 1'b0;
                    end
                end
            end
        end
        while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
            if (chk_q[0].at == cyc) begin
                check("state_spawn_piece", 32'(spawn_piece), 32'(chk_q[0].spawn));
                check("state_hold_piece", 32'(hold_piece), 32'(chk_q[0].hold));
                check("state_hold_used", 32'(hold_used), 32'(chk_q[0].used));
                check("state_spawn_valid", 32'(spawn_valid), 32'(chk_q[0].valid));
            end
            void'(chk_q.pop_front());
        end
        prev_remove = pieces_remove;
        prev_quiet  = rst || !game_active;
    end

    // Game-level reference model
    logic [2:0] m_active;
    logic [2:0] m_hold;
    logic       m_used;
    logic [2:0] m_offer;
    int         m_next = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_chk(input int at, input logic [2:0] sp, input logic v);
        chk_t c;
        c.at    = at;
        c.spawn = sp;
        c.hold  = m_hold;
        c.used  = m_used;
        c.valid = v;
        chk_q.push_back(c);
    endtask

    task automatic push_offer(input logic [2:0] piece, input int due);
        offer_t o;
        o.piece = piece;
        o.due   = due;
        exp_q.push_back(o);
        m_offer = piece;
    endtask

    task automatic expect_fetch(input int earliest);
        fetch_q.push_back(earliest);
        push_offer(bag[m_next % 1024], -1);
        m_next++;
    endtask

    task automatic start_game();
        game_active = 1'b1;
        m_hold      = BLANK;
        m_used      = 1'b0;
        m_active    = BLANK;
        expect_fetch(cyc + SD + 1);
    endtask

    task automatic flush();
        m_next   = m_next - fetch_q.size();
        fetch_q.delete();
        exp_q.delete();
        chk_q.delete();
        m_hold   = BLANK;
        m_used   = 1'b0;
        m_active = BLANK;
    endtask

    initial begin
        bit         abort;
        logic [2:0] tmp;
        abort = 1'b0;
        for (int i = 0; i < 1024; i++) bag[i] = 3'($urandom_range(1, 7));
        rst         = 1'b1;
        game_active = 1'b0;
        spawn_req   = 1'b0;
        hold_req    = 1'b0;
        spawn_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        start_game();

        for (int t = 0; t < 60 && !abort; t++) begin
            int mode;
            bit hs;
            bit quit;
            int streak;
            mode   = (t == 25) ? 1 : ((t == 35) ? 2 : 0);
            hs     = 1'b0;
            quit   = 1'b0;
            streak = 0;
            // Wait for the offer; random lock/hold pulses here must be ignored.
            for (int w = 0; w < 400; w++) begin
                if (t == 0) begin
                    spawn_ready = 1'b1;
                end else begin
                    spawn_req = ($urandom_range(0, 5) == 0);
                    hold_req  = ($urandom_range(0, 5) == 0);
                    if (streak > 0) begin
                        spawn_ready = 1'b0;
                        streak--;
                    end else if ($urandom_range(0, 9) == 0) begin
                        spawn_ready = 1'b0;
                        streak      = 4;
                    end else begin
                        spawn_ready = ($urandom_range(0, 3) != 0);
                    end
                end
                if (mode != 0) spawn_ready = 1'b0;
                @(negedge clk);
                hs = spawn_valid && spawn_ready;
                if (mode != 0 && spawn_valid) quit = 1'b1;
                step();
                spawn_req = 1'b0;
                hold_req  = 1'b0;
                if (hs || quit) break;
            end
            if (quit) begin
                if (mode == 1) begin
                    game_active = 1'b0;
                    flush();
                    step();
                    step();
                    start_game();
                end else begin
                    rst         = 1'b1;
                    spawn_ready = 1'b1;
                    flush();
                    step();
                    rst         = 1'b0;
                    spawn_ready = 1'b0;
                    start_game();
                end
                continue;
            end
            spawn_ready = 1'b0;
            if (!hs) begin
                check("offer_timeout", 32'(hs), 1);
                abort = 1'b1;
                break;
            end
            m_active = m_offer;
            push_chk(cyc, m_active, 1'b0);

            for (int a = 0; a < 20; a++) begin
                int r;
                repeat ($urandom_range(0, 2)) step();
                r = (a == 19) ? 0 : int'($urandom_range(0, 9));
                if (r < 4) begin
                    spawn_req = 1'b1;
                    hold_req  = ($urandom_range(0, 2) == 0);
                    m_used    = 1'b0;
                    m_active  = BLANK;
                    push_chk(cyc + 1, BLANK, 1'b0);
                    expect_fetch(cyc + SD + 1);
                    step();
                    spawn_req = 1'b0;
                    hold_req  = 1'b0;
                    if (t == 15) begin
                        repeat ($urandom_range(0, SD - 2)) step();
                        game_active = 1'b0;
                        flush();
                        step();
                        step();
                        start_game();
                    end
                    break;
                end
                hold_req = 1'b1;
                if (!HOLD_EN || m_used) begin
                    push_chk(cyc + 1, m_active, 1'b0);
                    step();
                    hold_req = 1'b0;
                end else if (m_hold == BLANK) begin
                    m_hold   = m_active;
                    m_used   = 1'b1;
                    m_active = BLANK;
                    push_chk(cyc + 1, BLANK, 1'b0);
                    expect_fetch(cyc + 1);
                    step();
                    hold_req = 1'b0;
                    break;
                end else begin
                    tmp      = m_hold;
                    m_hold   = m_active;
                    m_used   = 1'b1;
                    m_active = BLANK;
                    push_offer(tmp, cyc + 1);
                    push_chk(cyc + 1, tmp, 1'b1);
                    step();
                    hold_req = 1'b0;
                    break;
                end
            end
        end

        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piece_dispenser.md
PIECE_DISPENSER -- requirements
Module: piece_dispenser

Interface
REQ-001 SHALL have parameter SPAWN_DELAY, default 4, meaning cycles from lock (spawn_req) to new piece fetch; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port game_active, input, 1, level; high while a game is running.
REQ-005 SHALL have port queue_head, input, tile_type_t, front entry of the next-pieces queue; BLANK means no piece available.
REQ-006 SHALL have port pieces_remove, output, 1, single-cycle pulse that consumes queue_head.
REQ-007 SHALL have port spawn_req, input, 1, pulse from game logic when the active piece locks.
REQ-008 SHALL have port hold_req, input, 1, pulse requesting hold of the active piece.
REQ-009 SHALL have port spawn_valid, output, 1, spawn_piece is offered.
REQ-010 SHALL have port spawn_ready, input, 1, game logic accepts spawn_piece.
REQ-011 SHALL have port spawn_piece, output, tile_type_t, piece to spawn; BLANK when none is active or offered.
REQ-012 SHALL have port hold_piece, output, tile_type_t, held piece; BLANK when empty.
REQ-013 SHALL have port hold_used, output, 1, hold already used since last lock.

Function
REQ-014 SHALL implement FSM states IDLE, DELAY, FETCH, OFFER, ACTIVE.
REQ-015 IDLE: outputs quiet; game_active high -> DELAY, counter loaded with SPAWN_DELAY-1.
REQ-016 DELAY: counter decrements each cycle; at 0 -> FETCH; total DELAY dwell exactly SPAWN_DELAY cycles.
REQ-017 FETCH: while queue_head == BLANK, stay; when non-BLANK, capture into spawn_piece, pulse pieces_remove for exactly that cycle, -> OFFER next cycle.
REQ-018 pieces_remove SHALL never be asserted in two consecutive cycles, and never while queue_head == BLANK.
REQ-019 OFFER: spawn_valid high and spawn_piece stable until a cycle with spawn_ready high; that cycle -> ACTIVE; spawn_req and hold_req ignored in OFFER.
REQ-020 ACTIVE: spawn_valid low, spawn_piece holds active piece; spawn_req -> DELAY, clears hold_used, spawn_piece becomes BLANK.
REQ-021 ACTIVE with hold_req, hold_used low, hold_piece BLANK: hold_piece <= spawn_piece, hold_used <= 1, -> FETCH (no delay).
REQ-022 ACTIVE with hold_req, hold_used low, hold_piece non-BLANK: swap spawn_piece and hold_piece in one cycle, hold_used <= 1, -> OFFER.
REQ-023 hold_req with hold_used high SHALL be ignored, no state change.
REQ-024 spawn_req and hold_req in the same ACTIVE cycle: spawn_req wins, hold_req dropped.
REQ-025 game_active low in any state: next cycle -> IDLE, spawn_piece and hold_piece BLANK, hold_used 0, no pieces_remove pulse that cycle.
REQ-026 spawn_req/hold_req outside ACTIVE SHALL have no effect.

Reset
REQ-027 rst high at a clock edge SHALL force IDLE, spawn_piece BLANK, hold_piece BLANK, hold_used 0, spawn_valid 0, pieces_remove 0, counter 0.
REQ-028 Reset SHALL take priority over all inputs including mid-OFFER handshakes; no pulse on pieces_remove in the reset cycle.

Configuration
REQ-029 Macro PIECE_HOLD_EN SHALL gate the hold feature.
REQ-030 With PIECE_HOLD_EN defined, REQ-021..REQ-023 apply.
REQ-031 Without PIECE_HOLD_EN, hold_req SHALL be ignored, hold_piece tied BLANK, hold_used tied 0, no hold storage synthesized.

Verification
REQ-032 Reset, game_active=1, queue_head=T constant, spawn_ready=1 -> DELAY 4 cycles, pieces_remove 1 pulse in FETCH, spawn_valid high with spawn_piece=T one cycle.
REQ-033 queue_head=BLANK for 10 cycles in FETCH, then I -> no pulse during BLANK, single pulse when I appears, spawn_piece=I.
REQ-034 Active=S, hold empty, hold_req -> hold_piece=S, hold_used=1, next head O fetched without delay; second hold_req ignored.
REQ-035 Active=Z, hold=L, hold_used=0, hold_req -> spawn_piece=L, hold_piece=Z, no pieces_remove; spawn_req then clears hold_used.
REQ-036 spawn_req and hold_req same ACTIVE cycle -> DELAY entered, hold_piece unchanged; spawn_ready low 5 cycles in OFFER -> spawn_piece stable.
REQ-037 game_active dropped mid-DELAY or mid-OFFER -> IDLE next cycle, all outputs BLANK/0; build without PIECE_HOLD_EN -> hold_req ignored.
